mlp_layer_sequencer: RTL and testbench
======================================

Name: mlp_layer_sequencer

Overview:
Parametrised control unit for the MLP accelerator that sequences an arbitrary number of fully-connected layers through the shared processing-unit (PU) array. It replaces the fixed two-layer controller. Per-layer input count and neuron-batch count are run-time configured and captured at start. It drives weight/bias memory addresses, input-buffer selection, PU pipeline flush and result-buffer writes, and reports completion.

Parameters:
MAX_LAYERS, 4, number of layers supported; configuration ports are packed per layer.
LAYER_W, 2, width of layer index; must satisfy 2^LAYER_W >= MAX_LAYERS.
IN_W, 3, width of per-neuron input iterator (up to 2^IN_W inputs per neuron).
B_W, 2, width of neuron-batch iterator and result-write address.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin inference; sampled only in IDLE
cfg_num_layers  in  LAYER_W  number of layers minus one
cfg_in_last  in  MAX_LAYERS*IN_W  per-layer last input index; layer k occupies bits [k*IN_W +: IN_W]
cfg_batch_last  in  MAX_LAYERS*B_W  per-layer last batch index, same packing
mem_ready  in  1  weight/bias memories loaded
results_ready  in  1  PU array presents one finished batch this cycle
busy  out  1  high in every state except IDLE
finish  out  1  one-cycle pulse in DONE
layer_idx  out  LAYER_W  current layer
input_en  out  1  one-cycle pulse on accepted start; latches input vector
issue_valid  out  1  current address set is a valid PU operand
input_sel  out  IN_W  input-buffer select; equals in_itr
w_addr  out  B_W+IN_W  weight address {batch_itr, in_itr}
b_addr  out  B_W  bias address; equals batch_itr
bias_sel  out  1  high when issue_valid and in_itr is the layer's last index
res_we  out  1  result-buffer write strobe
res_addr  out  B_W  result-buffer write address
pipe_flush  out  1  clear PU pipeline registers

Behaviour:
- Reset: state=IDLE; all counters, captured config, layer_idx and done flags cleared. All outputs are 0. Asserting rst mid-run aborts immediately; no finish pulse is produced.
- States: IDLE, LOAD, RUN, SWITCH, DONE.
- IDLE:
  - On start=1: capture all cfg_* into registers, pulse input_en, go to LOAD.
  - Otherwise hold.
  - cfg_* changes outside IDLE have no effect.
- LOAD:
  - pipe_flush=1 while mem_ready=0.
  - On mem_ready=1: go to RUN with pipe_flush=0.
- RUN, issue side:
  - issue_valid=1 until all batches are issued.
  - in_itr increments every cycle and wraps to 0 after the captured in_last[layer_idx].
  - On that wrap, batch_itr increments.
  - The wrap out of batch_last sets issued_all. After that, issue_valid=0 and both iterators hold at 0.
- RUN, result side:
  - res_we = results_ready; the write goes to the current res_addr.
  - res_addr increments after each write.
  - A write with res_addr == batch_last[layer_idx] completes the layer.
  - Layer complete with layer_idx < captured num_layers: go to SWITCH.
  - Layer complete on the last layer: go to DONE.
- SWITCH (1 cycle):
  - pipe_flush=1.
  - Clear in_itr, batch_itr, res_addr and issued_all.
  - layer_idx increments at the end of the cycle.
  - Then go to RUN.
- DONE (1 cycle): finish=1, pipe_flush=1, then go to IDLE. layer_idx clears on entry to IDLE.
- results_ready outside RUN is ignored (res_we=0).
- A results_ready that arrives before issued_all is legal and is counted normally.
- A start received while busy is ignored.
- Degenerate config (all last indices 0, one layer) must complete: IDLE, LOAD, RUN (1 issue cycle), wait for 1 result, DONE.
- Counter widths: no overflow logic. Captured last indices are within field width by construction.

Optional Feature:
MLP_SEQ_STALL_EN adds input port stall (1 bit).
- With the macro: while stall=1 in RUN, in_itr, batch_itr and issue_valid freeze (issue_valid forced to 0, bias_sel=0). Result-side counting continues and state transitions on layer completion still occur.
- Without the macro: the port is absent and issue proceeds every RUN cycle.

Test Plan:
- Reset sequence: assert rst for 2 cycles, release -> all outputs 0, busy=0. Assert rst mid-RUN in layer 1 -> outputs 0 within the same cycle, no finish pulse.
- Two-layer run (num_layers=1; layer 0: in_last=7, batch_last=3; layer 1: in_last=3, batch_last=1):
  - Layer 0 produces 32 issue cycles with w_addr 0..31 and bias_sel high at in_itr=7.
  - After 4 results: 1 SWITCH cycle with pipe_flush=1, then layer_idx=1.
  - Layer 1 produces 8 issue cycles; after 2 results: finish pulses for 1 cycle.
- mem_ready held low 5 cycles after start -> state stays LOAD, pipe_flush=1 for 5 cycles, no issue_valid.
- Four-layer run with mixed sizes (in_last 2,5,0,7; batch_last 1,0,3,2) -> layer_idx steps 0..3, res_addr restarts at 0 each layer, exactly 2+1+4+3 res_we pulses, then one finish.
- Start pulsed during RUN and cfg changed mid-run -> no effect; the run completes with the captured configuration.
- With MLP_SEQ_STALL_EN: stall=1 for 3 cycles at in_itr=4 -> in_itr holds at 4 and issue_valid=0. Total issue cycles are unchanged, completion is delayed by 3 cycles.

Source files
------------

// File: rtl/mlp_layer_sequencer_if.sv
// rtl/mlp_layer_sequencer_if.sv - control/config bundle between MLP layer sequencer and datapath (optional stall under MLP_SEQ_STALL_EN)
interface mlp_layer_sequencer_if #(
    parameter int MAX_LAYERS = 4,
    parameter int LAYER_W    = 2,
    parameter int IN_W       = 3,
    parameter int B_W        = 2
) ();
    logic                         start;
    logic [LAYER_W-1:0]           cfg_num_layers;
    logic [MAX_LAYERS*IN_W-1:0]   cfg_in_last;
    logic [MAX_LAYERS*B_W-1:0]    cfg_batch_last;
    logic                         mem_ready;
    logic                         results_ready;
`ifdef MLP_SEQ_STALL_EN
    logic                         stall;
`endif
    logic                         busy;
    logic                         finish;
    logic [LAYER_W-1:0]           layer_idx;
    logic                         input_en;
    logic                         issue_valid;
    logic [IN_W-1:0]              input_sel;
    logic [B_W+IN_W-1:0]          w_addr;
    logic [B_W-1:0]               b_addr;
    logic                         bias_sel;
    logic                         res_we;
    logic [B_W-1:0]               res_addr;
    logic                         pipe_flush;

    modport master (
`ifdef MLP_SEQ_STALL_EN
        input  stall,
`endif
        input  start, cfg_num_layers, cfg_in_last, cfg_batch_last,
        input  mem_ready, results_ready,
        output busy, finish, layer_idx, input_en, issue_valid, input_sel,
        output w_addr, b_addr, bias_sel, res_we, res_addr, pipe_flush
    );

    modport slave (
`ifdef MLP_SEQ_STALL_EN
        output stall,
`endif
        output start, cfg_num_layers, cfg_in_last, cfg_batch_last,
        output mem_ready, results_ready,
        input  busy, finish, layer_idx, input_en, issue_valid, input_sel,
        input  w_addr, b_addr, bias_sel, res_we, res_addr, pipe_flush
    );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// rtl/mlp_layer_sequencer.sv - multi-layer MLP PU-array sequencer; MLP_SEQ_STALL_EN adds an issue-side stall input
module mlp_layer_sequencer #(
    parameter int MAX_LAYERS = 4,
    parameter int LAYER_W    = 2,
    parameter int IN_W       = 3,
    parameter int B_W        = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    mlp_layer_sequencer_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_SWITCH,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [LAYER_W-1:0] cap_num_layers;
    logic [IN_W-1:0]    cap_in_last    [MAX_LAYERS];
    logic [B_W-1:0]     cap_batch_last [MAX_LAYERS];
    logic [LAYER_W-1:0] layer_idx;

    logic [IN_W-1:0]    in_itr;
    logic [B_W-1:0]     batch_itr;
    logic [B_W-1:0]     res_addr;
    logic               issued_all;

    logic [IN_W-1:0]    cur_in_last;
    logic [B_W-1:0]     cur_batch_last;
    logic               stall_act;
    logic               issue_go;
    logic               in_wrap;
    logic               batch_wrap;
    logic               res_fire;
    logic               layer_done;
    logic               last_layer;

    // Limits of the layer currently being processed, from the captured config
    assign cur_in_last    = cap_in_last[layer_idx];
    assign cur_batch_last = cap_batch_last[layer_idx];

`ifdef MLP_SEQ_STALL_EN
    assign stall_act = bus.stall;
`else
    assign stall_act = 1'b0;
`endif

    // A stalled cycle freezes only the issue side; result counting keeps going
    assign issue_go   = (state == S_RUN) && !issued_all && !stall_act;
    assign in_wrap    = (in_itr == cur_in_last);
    assign batch_wrap = (batch_itr == cur_batch_last);
    assign res_fire   = (state == S_RUN) && bus.results_ready;
    assign layer_done = res_fire && (res_addr == cur_batch_last);
    assign last_layer = (layer_idx == cap_num_layers);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded control outputs
    always_comb begin
        state_nxt      = state;
        bus.busy       = 1'b0;
        bus.finish     = 1'b0;
        bus.input_en   = 1'b0;
        bus.pipe_flush = 1'b0;
        case (state)
            S_IDLE: begin
                // gated by rst so every output reads 0 while reset is held
                if (bus.start && !rst) begin
                    bus.input_en = 1'b1;
                    state_nxt    = S_LOAD;
                end
            end
            S_LOAD: begin
                bus.busy = 1'b1;
                if (bus.mem_ready) begin
                    state_nxt = S_RUN;
                end else begin
                    bus.pipe_flush = 1'b1;
                end
            end
            S_RUN: begin
                bus.busy = 1'b1;
                if (layer_done) begin
                    state_nxt = last_layer ? S_DONE : S_SWITCH;
                end
            end
            S_SWITCH: begin
                bus.busy       = 1'b1;
                bus.pipe_flush = 1'b1;
                state_nxt      = S_RUN;
            end
            S_DONE: begin
                bus.busy       = 1'b1;
                bus.finish     = 1'b1;
                bus.pipe_flush = 1'b1;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address/select outputs follow the iterators directly
    assign bus.issue_valid = issue_go;
    assign bus.input_sel   = in_itr;
    assign bus.w_addr      = {batch_itr, in_itr};
    assign bus.b_addr      = batch_itr;
    assign bus.bias_sel    = issue_go && in_wrap;
    assign bus.res_we      = res_fire;
    assign bus.res_addr    = res_addr;
    assign bus.layer_idx   = layer_idx;

    // Configuration is captured only on an accepted start so later cfg changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_num_layers <= '0;
            for (int k = 0; k < MAX_LAYERS; k++) begin
                cap_in_last[k]    <= '0;
                cap_batch_last[k] <= '0;
            end
        end else if (state == S_IDLE && bus.start) begin
            cap_num_layers <= bus.cfg_num_layers;
            for (int k = 0; k < MAX_LAYERS; k++) begin
                cap_in_last[k]    <= bus.cfg_in_last[k*IN_W +: IN_W];
                cap_batch_last[k] <= bus.cfg_batch_last[k*B_W +: B_W];
            end
        end
    end

    // Layer index advances leaving SWITCH and returns to 0 on the way back to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer_idx <= '0;
        end else if (state == S_SWITCH) begin
            layer_idx <= layer_idx + 1'b1;
        end else if (state == S_DONE) begin
            layer_idx <= '0;
        end
    end

    // Issue iterators and result counter; held cleared whenever not in RUN so each layer starts fresh
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_itr     <= '0;
            batch_itr  <= '0;
            res_addr   <= '0;
            issued_all <= 1'b0;
        end else if (state != S_RUN) begin
            in_itr     <= '0;
            batch_itr  <= '0;
            res_addr   <= '0;
            issued_all <= 1'b0;
        end else begin
            if (issue_go) begin
                if (in_wrap) begin
                    in_itr <= '0;
                    if (batch_wrap) begin
                        batch_itr  <= '0;
                        issued_all <= 1'b1;
                    end else begin
                        batch_itr <= batch_itr + 1'b1;
                    end
                end else begin
                    in_itr <= in_itr + 1'b1;
                end
            end
            if (res_fire) begin
                res_addr <= layer_done ? '0 : res_addr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// tb/tb_mlp_layer_sequencer.sv - self-checking bench for mlp_layer_sequencer (drives stall when MLP_SEQ_STALL_EN is defined)
module tb_mlp_layer_sequencer;
    localparam int MAX_LAYERS = 4;
    localparam int LAYER_W    = 2;
    localparam int IN_W       = 3;
    localparam int B_W        = 2;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cfg_nl;
    int   cfg_il [MAX_LAYERS];
    int   cfg_bl [MAX_LAYERS];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mlp_layer_sequencer_if #(
        .MAX_LAYERS(MAX_LAYERS), .LAYER_W(LAYER_W), .IN_W(IN_W), .B_W(B_W)
    ) bus ();

    mlp_layer_sequencer #(
        .MAX_LAYERS(MAX_LAYERS), .LAYER_W(LAYER_W), .IN_W(IN_W), .B_W(B_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_finish"}, bus.finish, 0);
        check({tag, "_layer_idx"}, bus.layer_idx, 0);
        check({tag, "_input_en"}, bus.input_en, 0);
        check({tag, "_issue_valid"}, bus.issue_valid, 0);
        check({tag, "_input_sel"}, bus.input_sel, 0);
        check({tag, "_w_addr"}, bus.w_addr, 0);
        check({tag, "_b_addr"}, bus.b_addr, 0);
        check({tag, "_bias_sel"}, bus.bias_sel, 0);
        check({tag, "_res_we"}, bus.res_we, 0);
        check({tag, "_res_addr"}, bus.res_addr, 0);
        check({tag, "_pipe_flush"}, bus.pipe_flush, 0);
    endtask

    task automatic drive_idle_inputs();
        bus.start         = 1'b0;
        bus.mem_ready     = 1'b0;
        bus.results_ready = 1'b0;
`ifdef MLP_SEQ_STALL_EN
        bus.stall         = 1'b0;
`endif
    endtask

    // Expected operand order for layer k: every batch, every input, in order
    task automatic fill_queue(input int k, inout int q[$]);
        q.delete();
        for (int b = 0; b <= cfg_bl[k]; b++)
            for (int i = 0; i <= cfg_il[k]; i++)
                q.push_back(b * (1 << IN_W) + i);
    endtask

    // phase: 0 idle, 1 load, 2 run, 3 switch, 4 done
    task automatic run_case(input int load_wait, input bit late, input bit noisy, input int abort_layer);
        int  q[$];
        int  k, rcount, phase, phase_nxt, cyc, issued, front;
        bit  rr, mr, st, exp_iv;
        logic [MAX_LAYERS*IN_W-1:0] pil;
        logic [MAX_LAYERS*B_W-1:0]  pbl;
        for (int i = 0; i < MAX_LAYERS; i++) begin
            pil[i*IN_W +: IN_W] = IN_W'(cfg_il[i]);
            pbl[i*B_W +: B_W]   = B_W'(cfg_bl[i]);
        end
        @(negedge clk);
        drive_idle_inputs();
        bus.cfg_num_layers = LAYER_W'(cfg_nl);
        bus.cfg_in_last    = pil;
        bus.cfg_batch_last = pbl;
        bus.start          = 1'b1;
        #1;
        check("start_input_en", bus.input_en, 1);
        check("start_busy", bus.busy, 0);
        @(negedge clk);
        bus.start = 1'b0;
        k = 0; rcount = 0; phase = 1; cyc = 0; issued = 0;
        fill_queue(0, q);
        while (phase != 0 && cyc < 3000) begin
            mr = (cyc >= load_wait);
            if (late) rr = (q.size() == 0) && ($urandom_range(0, 1) == 1);
            else      rr = ($urandom_range(0, 2) == 0);
            st = 1'b0;
`ifdef MLP_SEQ_STALL_EN
            st = ($urandom_range(0, 4) == 0);
            bus.stall = st;
`endif
            if (noisy) begin
                bus.start          = ($urandom_range(0, 1) == 1);
                bus.cfg_num_layers = LAYER_W'($urandom);
                bus.cfg_in_last    = (MAX_LAYERS*IN_W)'($urandom);
                bus.cfg_batch_last = (MAX_LAYERS*B_W)'($urandom);
            end
            bus.mem_ready     = mr;
            bus.results_ready = rr;
            if (abort_layer >= 0 && k == abort_layer && phase == 2 && issued >= 3) begin
                rst = 1'b1;
                bus.results_ready = 1'b0;
                bus.start = 1'b0;
                #1;
                check_all_zero("abort");
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("abort_no_finish", bus.finish, 0);
                    check("abort_busy", bus.busy, 0);
                end
                rst = 1'b0;
                drive_idle_inputs();
                @(negedge clk);
                check_all_zero("after_abort");
                return;
            end
            #1;
            phase_nxt = phase;
            check("busy", bus.busy, 1);
            check("finish", bus.finish, phase == 4);
            check("input_en_busy", bus.input_en, 0);
            check("layer_idx", bus.layer_idx, k);
            case (phase)
                1: begin
                    check("load_flush", bus.pipe_flush, !mr);
                    check("load_issue", bus.issue_valid, 0);
                    check("load_res_we", bus.res_we, 0);
                    if (mr) phase_nxt = 2;
                end
                2: begin
                    exp_iv = (q.size() > 0) && !st;
                    check("run_issue_valid", bus.issue_valid, exp_iv);
                    if (exp_iv) begin
                        front = q.pop_front();
                        check("w_addr", bus.w_addr, front);
                        check("input_sel", bus.input_sel, front % (1 << IN_W));
                        check("b_addr", bus.b_addr, front / (1 << IN_W));
                        check("bias_sel", bus.bias_sel, (front % (1 << IN_W)) == cfg_il[k]);
                        issued++;
                    end else begin
                        check("bias_sel_idle", bus.bias_sel, 0);
                    end
                    check("run_flush", bus.pipe_flush, 0);
                    check("res_we", bus.res_we, rr);
                    if (rr) begin
                        check("res_addr", bus.res_addr, rcount);
                        rcount++;
                        if (rcount == cfg_bl[k] + 1) begin
                            if (late)
                                check("issue_count", issued, (cfg_il[k] + 1) * (cfg_bl[k] + 1));
                            phase_nxt = (k < cfg_nl) ? 3 : 4;
                        end
                    end
                end
                3: begin
                    check("switch_flush", bus.pipe_flush, 1);
                    check("switch_issue", bus.issue_valid, 0);
                    check("switch_res_we", bus.res_we, 0);
                    k++;
                    rcount = 0;
                    issued = 0;
                    fill_queue(k, q);
                    phase_nxt = 2;
                end
                default: begin
                    check("done_flush", bus.pipe_flush, 1);
                    check("done_issue", bus.issue_valid, 0);
                    check("done_res_we", bus.res_we, 0);
                    phase_nxt = 0;
                end
            endcase
            phase = phase_nxt;
            @(negedge clk);
            cyc++;
        end
        check("run_completed_in_budget", phase, 0);
        drive_idle_inputs();
        #1;
        check("idle_busy", bus.busy, 0);
        check("idle_finish", bus.finish, 0);
        check("idle_layer_idx", bus.layer_idx, 0);
        check("idle_flush", bus.pipe_flush, 0);
        check("idle_issue", bus.issue_valid, 0);
    endtask

    task automatic set_cfg(input int nl, input int i0, input int i1, input int i2, input int i3,
                           input int b0, input int b1, input int b2, input int b3);
        cfg_nl = nl;
        cfg_il[0] = i0; cfg_il[1] = i1; cfg_il[2] = i2; cfg_il[3] = i3;
        cfg_bl[0] = b0; cfg_bl[1] = b1; cfg_bl[2] = b2; cfg_bl[3] = b3;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle_inputs();
        bus.cfg_num_layers = '0;
        bus.cfg_in_last    = '0;
        bus.cfg_batch_last = '0;
        @(negedge clk);
        check_all_zero("in_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        set_cfg(1, 7, 3, 0, 0, 3, 1, 0, 0);
        run_case(0, 1'b1, 1'b0, -1);
        run_case(5, 1'b0, 1'b0, -1);

        set_cfg(3, 2, 5, 0, 7, 1, 0, 3, 2);
        run_case(0, 1'b1, 1'b0, -1);
        run_case(2, 1'b0, 1'b0, -1);
        run_case(1, 1'b1, 1'b1, -1);

        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_case(0, 1'b1, 1'b0, -1);

        set_cfg(1, 7, 3, 0, 0, 3, 1, 0, 0);
        run_case(0, 1'b1, 1'b0, 1);
        run_case(0, 1'b0, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            set_cfg(int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            run_case(int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1), (r == 5), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
